// File: rtl/fpc_scheduler_if.sv
// Requester-side bundle for fpc_scheduler: operation handshake plus
// the per-requester response strobe and shared result/error bus.
interface fpc_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [15:0]           resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, req_mode,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/fpc_scheduler.sv
// Round-robin scheduler sharing one bf16 add/mul unit among NUM_REQ
// requesters, one operation in flight, with a result watchdog.
module fpc_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    fpc_scheduler_if.slave   req,
    output logic             fpc_in_valid,
    output logic [15:0]      fpc_in_a,
    output logic [15:0]      fpc_in_b,
    output logic             fpc_mode,
    input  logic             fpc_out_valid,
    input  logic [15:0]      fpc_out,
    output logic             busy,
    output logic [15:0]      op_count
);
    localparam int IW  = $clog2(NUM_REQ);
    localparam int IW1 = IW + 1;
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_gnt;
    logic [IW-1:0]   w_gnt;
    logic [IW-1:0]   w_idx;
    logic [IW1-1:0]  w_sum;
    logic            w_found;
    logic            w_timeout;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic            r_mode;
    logic [15:0]     r_data;
    logic            r_err;
    logic [15:0]     r_cnt;

    // Search starts one past the last served requester, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + IW1'(k);
            if (w_sum >= IW1'(NUM_REQ))
                w_sum = w_sum - IW1'(NUM_REQ);
            w_idx = w_sum[IW-1:0];
            if (!w_found && req.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (fpc_out_valid || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= IW'(NUM_REQ - 1);
            r_gnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_timer <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_gnt  <= w_gnt;
                r_a    <= req.req_a[{w_gnt, 4'h0} +: 16];
                r_b    <= req.req_b[{w_gnt, 4'h0} +: 16];
                r_mode <= req.req_mode[w_gnt];
            end
            if (r_state == S_ISSUE)
                r_timer <= '0;
            // A result landing on the timeout cycle still counts as success.
            if (r_state == S_WAIT) begin
                if (fpc_out_valid) begin
                    r_data <= fpc_out;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= 16'h0000;
                    r_err  <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_last <= r_gnt;
                if (!r_err)
                    r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign req.req_ready  = (r_state == S_IDLE && !rst && w_found) ?
                            (NUM_REQ'(1) << w_gnt) : '0;
    assign req.resp_valid = (r_state == S_RESP) ?
                            (NUM_REQ'(1) << r_gnt) : '0;
    assign req.resp_data  = r_data;
    assign req.resp_err   = r_err;

    assign fpc_in_valid = (r_state == S_ISSUE);
    assign fpc_in_a     = r_a;
    assign fpc_in_b     = r_b;
    assign fpc_mode     = r_mode;
    assign busy         = (r_state != S_IDLE);
    assign op_count     = r_cnt;
endmodule

// File: tb/tb_fpc_scheduler.sv
// Scoreboard bench for fpc_scheduler with a 2-cycle bf16 unit model
// and a round-robin reference predicting grants and responses.
module tb_fpc_scheduler;
    localparam int N  = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fpc_in_valid;
    logic [15:0] fpc_in_a;
    logic [15:0] fpc_in_b;
    logic        fpc_mode;
    logic        fpc_out_valid;
    logic [15:0] fpc_out;
    logic        busy;
    logic [15:0] op_count;

    fpc_scheduler_if #(.NUM_REQ(N)) bus ();

    fpc_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .fpc_in_valid (fpc_in_valid),
        .fpc_in_a     (fpc_in_a),
        .fpc_in_b     (fpc_in_b),
        .fpc_mode     (fpc_mode),
        .fpc_out_valid(fpc_out_valid),
        .fpc_out      (fpc_out),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
    } op_t;

    typedef struct {
        int          g;
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] d;
        logic        e;
        int          hs;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    op_t         pend[N][$];
    int          hs_g[$];
    int          hs_c[$];
    logic        gate_rnd = 1'b0;
    logic        unit_dead = 1'b0;
    logic        stray = 1'b0;
    logic [15:0] stray_d = 16'h0;
    int          m_last = N - 1;
    logic [15:0] m_cnt = 16'h0;
    logic        chk_next = 1'b0;
    int          last_g = -1;
    logic [15:0] last_d = 16'h0;
    logic        last_e = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     name, act, want, cyc);
        end
    endtask

    function automatic real b2r(logic [15:0] x);
        logic [10:0] e;
        if (x[14:7] == 8'h0) return 0.0;
        e = 11'(x[14:7]) + 11'd896;
        return $bitstoreal({x[15], e, x[6:0], 45'h0});
    endfunction

    // Round-to-nearest-even from double to bf16 (normal range only).
    function automatic logic [15:0] r2b(real r);
        logic [63:0] d;
        logic [8:0]  mt;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 15'h0};
        e  = int'(d[62:52]) - 1023 + 127;
        mt = {2'b01, d[51:45]};
        if (d[44] && ((|d[43:0]) || mt[0])) mt = mt + 9'd1;
        if (mt[8]) begin
            e++;
            mt = mt >> 1;
        end
        return {d[63], 8'(e), mt[6:0]};
    endfunction

    function automatic logic [15:0] op_ref(logic [15:0] a, logic [15:0] b,
                                           logic m);
        if (m) return r2b(b2r(a) * b2r(b));
        return r2b(b2r(a) + b2r(b));
    endfunction

    function automatic logic [15:0] rand_bf16();
        return {1'($urandom), 8'($urandom_range(134, 120)), 7'($urandom)};
    endfunction

    // Shared unit: two-stage pipeline, optionally silenced or spoofed.
    logic        v1, v2;
    logic [15:0] d1, d2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= 16'h0;
            d2 <= 16'h0;
        end else begin
            v1 <= fpc_in_valid;
            d1 <= op_ref(fpc_in_a, fpc_in_b, fpc_mode);
            v2 <= v1;
            d2 <= d1;
        end
    end
    assign fpc_out_valid = (v2 && !unit_dead) || stray;
    assign fpc_out       = stray ? stray_d : d2;

    function automatic int pick(logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = (pend[i].size() > 0) &&
                (!gate_rnd || ($urandom_range(3) != 0));
            bus.req_valid[i] = v;
            if (v) begin
                bus.req_a[16*i +: 16] = pend[i][0].a;
                bus.req_b[16*i +: 16] = pend[i][0].b;
                bus.req_mode[i]       = pend[i][0].m;
            end else begin
                bus.req_a[16*i +: 16] = 16'($urandom);
                bus.req_b[16*i +: 16] = 16'($urandom);
                bus.req_mode[i]       = 1'($urandom);
            end
        end
    endtask

    task automatic sample();
        logic [N-1:0] er;
        int p;
        int g;
        if (rst) return;
        p  = pick(bus.req_valid);
        er = '0;
        if (exp_q.size() == 0 && p >= 0) er[p] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        g = -1;
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i] && bus.req_valid[i]) g = i;
        if (g >= 0 && pend[g].size() > 0) begin
            exp_t e;
            op_t  o;
            o    = pend[g].pop_front();
            e.g  = g;
            e.a  = o.a;
            e.b  = o.b;
            e.m  = o.m;
            e.e  = unit_dead;
            e.d  = unit_dead ? 16'h0 : op_ref(o.a, o.b, o.m);
            e.hs = cyc;
            exp_q.push_back(e);
            m_last = g;
            hs_g.push_back(g);
            hs_c.push_back(cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_op(int i, logic [15:0] a, logic [15:0] b, logic m);
        op_t o;
        o.a = a;
        o.b = b;
        o.m = m;
        pend[i].push_back(o);
    endtask

    function automatic bit outstanding();
        if (exp_q.size() > 0) return 1'b1;
        for (int i = 0; i < N; i++)
            if (pend[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(int budget, string name);
        int n = 0;
        while (outstanding() && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no completion within %0d cycles", name, budget);
        end
        step();
        step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) pend[i].delete();
        hs_g.delete();
        hs_c.delete();
        m_last        = N - 1;
        m_cnt         = 16'h0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_mode  = '0;
        #1;
        chk("reset_resp", 64'({bus.resp_valid, bus.resp_data, bus.resp_err}), 64'h0);
        chk("reset_fpc", 64'({fpc_in_valid, fpc_in_a, fpc_in_b, fpc_mode}), 64'h0);
        chk("reset_misc", 64'({op_count, busy}), 64'h0);
        chk("reset_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("reset_ready_hold", 64'(bus.req_ready), 64'h0);
        rst = 1'b0;
        drive();
    endtask

    // Monitor: pops the scoreboard whenever a response strobe appears.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk_next = 1'b0;
            end else begin
                logic         exp_iv;
                logic [N-1:0] ev;
                exp_t         e;
                exp_iv = (exp_q.size() > 0) && (cyc == exp_q[0].hs + 1);
                chk("fpc_in_valid", 64'(fpc_in_valid), 64'(exp_iv));
                if (exp_iv)
                    chk("fpc_in_ops", 64'({fpc_in_a, fpc_in_b, fpc_mode}),
                        64'({exp_q[0].a, exp_q[0].b, exp_q[0].m}));
                if (chk_next) begin
                    chk("op_count", 64'(op_count), 64'(m_cnt));
                    chk("busy_after_resp", 64'(busy), 64'h0);
                    chk_next = 1'b0;
                end
                if (bus.resp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 64'(bus.resp_valid), 64'h0);
                    end else begin
                        e  = exp_q.pop_front();
                        ev = '0;
                        ev[e.g] = 1'b1;
                        chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
                        chk("resp_data", 64'(bus.resp_data), 64'(e.d));
                        chk("resp_err", 64'(bus.resp_err), 64'(e.e));
                        chk("latency", 64'(cyc - e.hs),
                            64'(e.e ? TO + 2 : 4));
                        if (!e.e) m_cnt = m_cnt + 16'd1;
                        last_g   = e.g;
                        last_d   = bus.resp_data;
                        last_e   = bus.resp_err;
                        chk_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq[5] = '{0, 1, 2, 3, 0};
        int n;
        int sent;
        #2;
        reset_dut();

        push_op(0, 16'h3F80, 16'h4000, 1'b0);
        drive();
        wait_idle(40, "single");
        chk("single_dest", 64'(last_g), 64'd0);
        chk("single_data", 64'(last_d), 64'h4040);
        chk("single_err", 64'(last_e), 64'h0);
        chk("single_count", 64'(op_count), 64'd1);

        reset_dut();
        for (int i = 0; i < N; i++)
            push_op(i, rand_bf16(), rand_bf16(), 1'(i));
        push_op(0, rand_bf16(), rand_bf16(), 1'b1);
        drive();
        wait_idle(100, "rr");
        chk("rr_grants", 64'(hs_g.size()), 64'd5);
        if (hs_g.size() == 5) begin
            for (int k = 0; k < 5; k++)
                chk("rr_order", 64'(hs_g[k]), 64'(seq[k]));
            for (int k = 1; k < 5; k++)
                chk("rr_spacing", 64'(hs_c[k] - hs_c[k-1]), 64'd5);
        end

        push_op(2, rand_bf16(), rand_bf16(), 1'b0);
        drive();
        wait_idle(40, "fair_pre");
        hs_g.delete();
        push_op(2, rand_bf16(), rand_bf16(), 1'b1);
        push_op(3, rand_bf16(), rand_bf16(), 1'b0);
        drive();
        wait_idle(60, "fair");
        chk("fair_first", 64'(hs_g.size() > 0 ? hs_g[0] : -1), 64'd3);
        chk("fair_second", 64'(hs_g.size() > 1 ? hs_g[1] : -1), 64'd2);

        unit_dead = 1'b1;
        push_op(1, rand_bf16(), rand_bf16(), 1'b0);
        drive();
        wait_idle(60, "timeout");
        chk("to_err", 64'(last_e), 64'h1);
        chk("to_data", 64'(last_d), 64'h0);
        chk("to_count", 64'(op_count), 64'(m_cnt));

        hs_g.delete();
        push_op(3, rand_bf16(), rand_bf16(), 1'b0);
        drive();
        n = 0;
        while (hs_g.size() == 0 && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        chk("busy_wait", 64'(busy), 64'h1);
        reset_dut();
        unit_dead = 1'b0;
        push_op(0, rand_bf16(), rand_bf16(), 1'b0);
        push_op(1, rand_bf16(), rand_bf16(), 1'b1);
        drive();
        wait_idle(60, "post_reset");
        chk("post_reset_first", 64'(hs_g.size() > 0 ? hs_g[0] : -1), 64'd0);
        chk("post_reset_second", 64'(hs_g.size() > 1 ? hs_g[1] : -1), 64'd1);

        stray_d = 16'h1234;
        stray   = 1'b1;
        step();
        stray = 1'b0;
        step();
        step();
        chk("stray_count", 64'(op_count), 64'(m_cnt));
        chk("stray_busy", 64'(busy), 64'h0);
        push_op(1, 16'h4000, 16'h4040, 1'b1);
        drive();
        wait_idle(40, "mul");
        chk("mul_dest", 64'(last_g), 64'd1);
        chk("mul_data", 64'(last_d), 64'h40C0);

        gate_rnd = 1'b1;
        sent = 0;
        n    = 0;
        while (sent < 200 && n < 5000) begin
            int tot = 0;
            for (int i = 0; i < N; i++) tot += pend[i].size();
            if (tot < 3) begin
                push_op($urandom_range(N - 1), rand_bf16(), rand_bf16(),
                        1'($urandom));
                sent++;
            end
            step();
            n++;
        end
        wait_idle(2000, "random");
        gate_rnd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
